zfnaf_brick_encoder: RTL and testbench

//  Consumes the dense FP16 activation stream leaving the ReLU stage, one value per cycle.
//  Re-encodes each brick of BRICK_SIZE values in zero-free form: only non-zero values are

---
 rtl/cnv_fp16_pkg.sv | 24 ++
 rtl/zfnaf_sync_fifo.sv | 72 +++++++
 rtl/zfnaf_brick_encoder.sv | 169 ++++++++++++++++
 tb/tb_zfnaf_brick_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnv_fp16_pkg.sv
// Shared FP16 definitions for the cnvlutin activation path: field widths,
// the default brick size and the zero test shared with the ReLU stage.
package cnv_fp16_pkg;

  localparam int FP16_W     = 16;
  localparam int EXP_W      = 5;
  localparam int MAN_W      = 10;
  localparam int BRICK_SIZE = 16;

  // True for +0, -0 and any value with the sign bit set. Negative values
  // should never leave ReLU; dropping them here keeps the stream zero-free
  // even if an upstream stage misbehaves. Subnormals, Inf and NaN with a
  // clear sign bit are treated as ordinary non-zero values.
  function automatic logic fp16_is_zero_or_neg(input logic [FP16_W-1:0] x);
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
    sign = x[FP16_W-1];
    expo = x[MAN_W +: EXP_W];
    man  = x[MAN_W-1:0];
    return sign || ((expo == '0) && (man == '0));
  endfunction

endpackage

// File: rtl/zfnaf_sync_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// The caller must not push while full; a pop on empty is ignored.
module zfnaf_sync_fifo #(
  parameter  int WIDTH = 21,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q < CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for pointers and occupancy; DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge values of its peers; blocking = here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; slots are only read once written,
  // and the consumer masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/zfnaf_brick_encoder.sv
// Zero-free brick encoder: turns the dense post-ReLU FP16 stream into
// (value, offset, last) entries for the non-zero activations of each brick.
// The newest non-zero is parked in a pending register until it is known
// whether another non-zero follows in the same brick, which fixes out_last.
module zfnaf_brick_encoder
  import cnv_fp16_pkg::FP16_W, cnv_fp16_pkg::fp16_is_zero_or_neg;
#(
  parameter int BRICK_SIZE = cnv_fp16_pkg::BRICK_SIZE,
  parameter int OFF_W      = $clog2(BRICK_SIZE),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP16_W-1:0] out_value,
  output logic [OFF_W-1:0]  out_offset,
  output logic              out_last,
  output logic              brick_done,
  output logic [OFF_W:0]    brick_nnz
);

  localparam int ENTRY_W = FP16_W + OFF_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [OFF_W:0]    nnz_q, nnz_d;
  logic              pend_v_q, pend_v_d;
  logic [FP16_W-1:0] pend_val_q, pend_val_d;
  logic [OFF_W-1:0]  pend_off_q, pend_off_d;
  logic              done_q, done_d;
  logic [OFF_W:0]    brick_nnz_q, brick_nnz_d;

  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_space;
  logic               accept;
  logic               in_nz;
  logic               is_end;
  logic [OFF_W:0]     brick_total;

  // Readiness comes from the registered FIFO count only, so there is no
  // combinational path from out_ready to in_ready.
  assign fifo_space  = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign in_ready    = rst_n && (state_q == S_RUN) && fifo_space;
  assign accept      = in_valid && in_ready;
  assign in_nz       = !fp16_is_zero_or_neg(in_data);
  assign is_end      = (offset_q == OFF_W'(BRICK_SIZE - 1));
  assign brick_total = nnz_q + (OFF_W + 1)'(in_nz);

  // Encoder decisions: offset tracking, pending register, FIFO push, brick close.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    nnz_d       = nnz_q;
    pend_v_d    = pend_v_q;
    pend_val_d  = pend_val_q;
    pend_off_d  = pend_off_q;
    done_d      = 1'b0;
    brick_nnz_d = brick_nnz_q;
    push        = 1'b0;
    push_data   = {pend_val_q, pend_off_q, 1'b0};

    if (state_q == S_RUN) begin
      if (accept) begin
        offset_d = is_end ? '0 : offset_q + 1'b1;
        if (!is_end) begin
          if (in_nz) begin
            // The previous pending value now has a successor, so it is not last.
            push       = pend_v_q;
            pend_v_d   = 1'b1;
            pend_val_d = in_data;
            pend_off_d = offset_q;
            nnz_d      = brick_total;
          end
        end else if (in_nz && pend_v_q) begin
          // Two entries must leave at the brick end but only one push fits per
          // cycle; the final one goes out from S_FLUSH.
          push       = 1'b1;
          pend_val_d = in_data;
          pend_off_d = offset_q;
          nnz_d      = brick_total;
          state_d    = S_FLUSH;
        end else if (in_nz) begin
          push        = 1'b1;
          push_data   = {in_data, offset_q, 1'b1};
          done_d      = 1'b1;
          brick_nnz_d = brick_total;
          nnz_d       = '0;
        end else if (pend_v_q) begin
          push        = 1'b1;
          push_data   = {pend_val_q, pend_off_q, 1'b1};
          pend_v_d    = 1'b0;
          done_d      = 1'b1;
          brick_nnz_d = brick_total;
          nnz_d       = '0;
        end else begin
          done_d      = 1'b1;
          brick_nnz_d = '0;
          nnz_d       = '0;
        end
      end
    end else begin
      if (fifo_space) begin
        push        = 1'b1;
        push_data   = {pend_val_q, pend_off_q, 1'b1};
        pend_v_d    = 1'b0;
        done_d      = 1'b1;
        brick_nnz_d = nnz_q;
        nnz_d       = '0;
        state_d     = S_RUN;
      end
    end
  end

  // Encoder state registers; reset discards any partial brick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      offset_q    <= '0;
      nnz_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_val_q  <= '0;
      pend_off_q  <= '0;
      done_q      <= 1'b0;
      brick_nnz_q <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      nnz_q       <= nnz_d;
      pend_v_q    <= pend_v_d;
      pend_val_q  <= pend_val_d;
      pend_off_q  <= pend_off_d;
      done_q      <= done_d;
      brick_nnz_q <= brick_nnz_d;
    end
  end

  zfnaf_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // Head fields are masked while empty so the outputs read zero after reset.
  assign out_valid  = (fifo_count != '0);
  assign out_value  = out_valid ? head[ENTRY_W-1 -: FP16_W] : '0;
  assign out_offset = out_valid ? head[OFF_W:1] : '0;
  assign out_last   = out_valid ? head[0] : 1'b0;
  assign brick_done = done_q;
  assign brick_nnz  = brick_nnz_q;

endmodule

// File: tb/tb_zfnaf_brick_encoder.sv
// Self-checking bench for zfnaf_brick_encoder: a brick-level reference model
// fills a scoreboard of expected entries and brick_nnz values whenever a brick
// is queued; outputs are popped and compared as the DUT hands them over.
module tb_zfnaf_brick_encoder;

  localparam int BS = 16;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  off;
    logic        last;
  } entry_t;

  typedef struct {
    logic [15:0] v [BS];
    int          nnz;
    int          stalls;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_value;
  logic [3:0]  out_offset;
  logic        out_last;
  logic        brick_done;
  logic [4:0]  brick_nnz;

  int checks = 0;
  int errors = 0;

  logic [15:0] stim_q [$];
  entry_t      exp_q  [$];
  int          nnz_q  [$];

  int          valid_pct = 100;
  int          ready_pct = 100;
  int          acc_cnt   = 0;
  int          stall_cnt = 0;
  logic        hold_v    = 1'b0;
  logic [20:0] hold_data = '0;

  zfnaf_brick_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_offset (out_offset),
    .out_last   (out_last),
    .brick_done (brick_done),
    .brick_nnz  (brick_nnz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: queues the brick's inputs and its expected entries.
  // Returns the non-zero count derived from the values themselves.
  function automatic int queue_brick(input logic [15:0] v [BS]);
    int nz_idx [$];
    for (int i = 0; i < BS; i++) begin
      stim_q.push_back(v[i]);
      if (!v[i][15] && (v[i][14:0] != 15'h0)) nz_idx.push_back(i);
    end
    for (int k = 0; k < nz_idx.size(); k++) begin
      entry_t e;
      e.value = v[nz_idx[k]];
      e.off   = 4'(nz_idx[k]);
      e.last  = (k == nz_idx.size() - 1);
      exp_q.push_back(e);
    end
    return nz_idx.size();
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later, well before the
  // next rising edge where the transfers actually happen.
  task automatic cycle();
    @(negedge clk);
    if (stim_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      in_data  = stim_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 16'h0;
    end
    out_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (hold_v) check("out_hold", {out_valid, out_value, out_offset, out_last}, {1'b1, hold_data});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", out_valid, 1'b0);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("out_entry", {out_value, out_offset, out_last}, {e.value, e.off, e.last});
      end
    end
    if (brick_done) begin
      if (nnz_q.size() == 0) check("done_unexpected", brick_done, 1'b0);
      else check("brick_nnz", brick_nnz, nnz_q.pop_front());
    end
    if (!in_ready) stall_cnt++;
    if (in_valid && in_ready) begin
      void'(stim_q.pop_front());
      acc_cnt++;
    end
    hold_v    = out_valid && !out_ready;
    hold_data = {out_value, out_offset, out_last};
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((stim_q.size() + exp_q.size() + nnz_q.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    if ((stim_q.size() + exp_q.size() + nnz_q.size()) != 0)
      check("drain_timeout", stim_q.size() + exp_q.size() + nnz_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_fields"}, {out_value, out_offset, out_last}, 21'h0);
    check({tag, "_brick_done"}, brick_done, 1'b0);
    check({tag, "_brick_nnz"}, brick_nnz, 5'h0);
  endtask

  localparam int NT = 7;
  vec_t        tbl [NT];
  logic [15:0] br [BS];
  int          n;

  initial begin
    // Table: values, hand-derived nnz, and flush stalls (only when offset 15
    // is non-zero while an earlier non-zero is still pending).
    for (int i = 0; i < NT; i++) begin
      for (int j = 0; j < BS; j++) tbl[i].v[j] = 16'h0;
      tbl[i].stalls = 0;
    end
    tbl[0].v[0] = 16'h3C00; tbl[0].v[3] = 16'h4000; tbl[0].nnz = 2;
    tbl[1].v[1] = 16'h8000; tbl[1].v[9] = 16'h8000; tbl[1].v[15] = 16'h8000; tbl[1].nnz = 0;
    tbl[2].v[4] = 16'hBC00; tbl[2].v[8] = 16'h8001; tbl[2].v[15] = 16'hFC00; tbl[2].nnz = 0;
    for (int j = 0; j < BS; j++) tbl[3].v[j] = 16'h0001;
    tbl[3].nnz = 16; tbl[3].stalls = 1;
    tbl[4].v[0] = 16'h7C00; tbl[4].v[7] = 16'h7E00; tbl[4].v[15] = 16'h0200;
    tbl[4].nnz = 3; tbl[4].stalls = 1;
    tbl[5].v[15] = 16'h3C00; tbl[5].nnz = 1;
    tbl[6].v[0] = 16'h4500; tbl[6].nnz = 1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven bricks, each drained on its own.
    for (int t = 0; t < NT; t++) begin
      void'(queue_brick(tbl[t].v));
      nnz_q.push_back(tbl[t].nnz);
      stall_cnt = 0;
      run_until_idle(200);
      check($sformatf("stalls_t%0d", t), stall_cnt, tbl[t].stalls);
    end

    // Back-pressure: a dense brick with out_ready low fills the 4-entry FIFO;
    // the fifth non-zero sits in pend, so exactly five inputs are taken.
    for (int j = 0; j < BS; j++) br[j] = 16'h3C00 + 16'(j);
    nnz_q.push_back(queue_brick(br));
    ready_pct = 0;
    acc_cnt   = 0;
    repeat (20) cycle();
    check("full_accepted", acc_cnt, 5);
    check("full_in_ready", in_ready, 1'b0);
    ready_pct = 100;
    run_until_idle(200);

    // Back-to-back bricks ending in a non-zero, no idle gap between them.
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < BS; j++) br[j] = ((j % (b + 2)) == 0 || j == 15) ? 16'h3800 + 16'(b * 16 + j) : 16'h0;
      nnz_q.push_back(queue_brick(br));
    end
    run_until_idle(300);

    // Reset after offset 7 with one entry queued and one pending.
    ready_pct = 0;
    for (int j = 0; j < 8; j++) stim_q.push_back((j == 2) ? 16'h3C00 : (j == 5) ? 16'h4400 : 16'h0);
    repeat (10) cycle();
    check("pre_rst_out_valid", out_valid, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    stim_q.delete();
    exp_q.delete();
    nnz_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    ready_pct = 100;
    void'(queue_brick(tbl[0].v));
    nnz_q.push_back(tbl[0].nnz);
    run_until_idle(200);

    // Random traffic: 100 bricks, random valid/ready, mixed value classes.
    valid_pct = 80;
    ready_pct = 50;
    for (int b = 0; b < 100; b++) begin
      for (int j = 0; j < BS; j++) begin
        case ($urandom_range(3))
          0:       br[j] = 16'h0;
          1:       br[j] = 16'h8000 | 16'($urandom_range(32767));
          default: br[j] = 16'($urandom_range(32767));
        endcase
      end
      n = queue_brick(br);
      nnz_q.push_back(n);
    end
    run_until_idle(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
